uart_echo_responder: RTL and testbench

- Far-end responder for the uart link. Consumes bytes delivered by a uart receiver (p_data/data_valid pulse) and returns each byte, in order, through a uart transmitter (p_data/data_valid/busy handshake).
- Contains a small FIFO that absorbs back-to-back received bytes while the transmitter is busy.
- Contains a transmit-handshake FSM with a busy timeout.
- Keeps sticky overflow and drop statistics for link bring-up and loopback testing.

---
 rtl/uart_echo_responder_if.sv | 28 ++
 rtl/uart_echo_responder.sv | 138 +++++++++++++
 tb/tb_uart_echo_responder.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_echo_responder_if.sv
// Byte handshake bundle between a uart rx/tx pair and the echo responder.
interface uart_echo_responder_if #(
  parameter int unsigned DWIDTH = 8
);
  logic [DWIDTH-1:0] rx_data;
  logic              rx_valid;
  logic              tx_busy;
  logic [DWIDTH-1:0] tx_data;
  logic              tx_valid;

  // Link side: supplies received bytes and transmitter status.
  modport master (
    output rx_data,
    output rx_valid,
    output tx_busy,
    input  tx_data,
    input  tx_valid
  );

  // Responder side: consumes received bytes, loads the transmitter.
  modport slave (
    input  rx_data,
    input  rx_valid,
    input  tx_busy,
    output tx_data,
    output tx_valid
  );
endinterface

// File: rtl/uart_echo_responder.sv
// Far-end uart echo: buffers received bytes in a small FIFO and replays them
// in order through the transmitter handshake, with a busy-rise timeout and
// sticky drop/timeout statistics.
module uart_echo_responder #(
  parameter int unsigned DWIDTH  = 8,
  parameter int unsigned AWIDTH  = 2,
  parameter int unsigned BUSY_TO = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_echo_responder_if.slave link,
  input  logic                 enable,
  input  logic                 clr_stat,
  output logic [AWIDTH:0]      fifo_level,
  output logic                 overflow,
  output logic [7:0]           drop_cnt,
  output logic                 tx_err,
  output logic                 idle
);

  localparam int unsigned DEPTH = 1 << AWIDTH;
  localparam int unsigned TW    = 8;
  localparam logic [AWIDTH:0] FULL     = (AWIDTH+1)'(DEPTH);
  localparam logic [TW-1:0]   TO_LIMIT = TW'(BUSY_TO);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD      = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [TW-1:0]     timer, timer_nxt;
  logic              pop, push, drop, accept, timeout;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0] wr_ptr, rd_ptr;

  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  always_comb begin
    accept = link.rx_valid && enable;
    push   = accept && ((fifo_level != FULL) || pop);
    drop   = accept && (fifo_level == FULL) && !pop;
  end

  // FSM state, busy timer and the registered load pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      timer         <= '0;
      link.tx_valid <= 1'b0;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      link.tx_valid <= (state_nxt == S_LOAD);
    end
  end

  // Next-state logic; the head is popped on the edge that enters LOAD.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    pop       = 1'b0;
    timeout   = 1'b0;
    case (state)
      S_IDLE: begin
        if (fifo_level != '0) begin
          state_nxt = S_LOAD;
          pop       = 1'b1;
        end
      end
      S_LOAD: begin
        state_nxt = S_WAIT_BUSY;
        timer_nxt = '0;
      end
      S_WAIT_BUSY: begin
        if (link.tx_busy) begin
          state_nxt = S_WAIT_DONE;
        end else begin
          timer_nxt = timer + TW'(1);
          if (timer_nxt == TO_LIMIT) begin
            timeout   = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!link.tx_busy) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= link.rx_data;
  end

  // FIFO pointers, occupancy and the byte handed to the transmitter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      link.tx_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AWIDTH'(1);
      if (pop) begin
        rd_ptr       <= rd_ptr + AWIDTH'(1);
        link.tx_data <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + (AWIDTH+1)'(1);
        2'b01:   fifo_level <= fifo_level - (AWIDTH+1)'(1);
        default: ;
      endcase
    end
  end

  // Sticky statistics; a clear pulse beats a same-cycle drop or timeout.
  always_ff @(posedge clk) begin
    if (!rst || clr_stat) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
      tx_err   <= 1'b0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
      if (timeout) tx_err <= 1'b1;
    end
  end

  // Nothing queued, nothing in flight, transmitter quiet.
  assign idle = (fifo_level == '0) && (state == S_IDLE) && !link.tx_busy;

endmodule

// File: tb/tb_uart_echo_responder.sv
// Bench for uart_echo_responder: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based reference of the echo behaviour.
module tb_uart_echo_responder;

  localparam int unsigned DWIDTH  = 8;
  localparam int unsigned AWIDTH  = 2;
  localparam int unsigned DEPTH   = 1 << AWIDTH;
  localparam int unsigned BUSY_TO = 15;

  // Reference transmit-engine phases
  localparam int P_FREE  = 0;
  localparam int P_PULSE = 1;
  localparam int P_RISE  = 2;
  localparam int P_FALL  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              clr_stat;
  logic [AWIDTH:0]   fifo_level;
  logic              overflow;
  logic [7:0]        drop_cnt;
  logic              tx_err;
  logic              idle;

  uart_echo_responder_if #(.DWIDTH(DWIDTH)) bus ();

  uart_echo_responder #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH),
    .BUSY_TO(BUSY_TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .link      (bus),
    .enable    (enable),
    .clr_stat  (clr_stat),
    .fifo_level(fifo_level),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .tx_err    (tx_err),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  logic [7:0] mq[$];
  int         m_phase = P_FREE;
  int         m_wait  = 0;
  bit         m_txv   = 1'b0;
  logic [7:0] m_txd   = 8'h00;
  bit         m_ovf   = 1'b0;
  int         m_drop  = 0;
  bit         m_err   = 1'b0;

  // Transmitter emulation / manual busy control
  bit manual   = 1'b1;
  bit man_busy = 1'b0;
  bit em_fixed = 1'b1;
  bit em_on    = 1'b0;
  bit em_never = 1'b0;
  int em_age   = 0;
  int em_d     = 0;
  int em_len   = 0;

  logic [7:0] obs[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the reference, using the inputs applied this cycle.
  task automatic model_step();
    bit take, acc, keep, err_evt;
    if (!rst) begin
      mq.delete();
      m_phase = P_FREE;
      m_wait  = 0;
      m_txv   = 1'b0;
      m_txd   = 8'h00;
      m_ovf   = 1'b0;
      m_drop  = 0;
      m_err   = 1'b0;
    end else begin
      take    = (m_phase == P_FREE) && (mq.size() != 0);
      acc     = bus.rx_valid && enable;
      keep    = acc && ((mq.size() < int'(DEPTH)) || take);
      err_evt = 1'b0;
      m_txv   = take;
      case (m_phase)
        P_FREE: begin
          if (take) begin
            m_txd   = mq.pop_front();
            m_phase = P_PULSE;
          end
        end
        P_PULSE: begin
          m_phase = P_RISE;
          m_wait  = 0;
        end
        P_RISE: begin
          if (bus.tx_busy) m_phase = P_FALL;
          else begin
            m_wait++;
            if (m_wait >= int'(BUSY_TO)) begin
              err_evt = 1'b1;
              m_phase = P_FREE;
            end
          end
        end
        default: if (!bus.tx_busy) m_phase = P_FREE;
      endcase
      if (keep) mq.push_back(bus.rx_data);
      if (clr_stat) begin
        m_ovf  = 1'b0;
        m_drop = 0;
        m_err  = 1'b0;
      end else begin
        if (acc && !keep) begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end
        if (err_evt) m_err = 1'b1;
      end
    end
  endtask

  // Busy for the current cycle: a transmitter that rises some cycles after a load.
  task automatic drive_busy();
    if (rst == 1'b0) em_on = 1'b0;
    else if (m_txv) begin
      em_on  = 1'b1;
      em_age = 0;
      if (em_fixed) begin
        em_d = 0; em_len = 2; em_never = 1'b0;
      end else begin
        em_d     = int'($urandom_range(0, 3));
        em_len   = int'($urandom_range(1, 6));
        em_never = ($urandom_range(0, 9) == 0);
      end
    end else if (em_on) em_age++;
    bus.tx_busy = manual ? man_busy
                : (em_on && !em_never && (em_age >= 1 + em_d) && (em_age < 1 + em_d + em_len));
  endtask

  task automatic check_all();
    check_val("tx_valid",   32'(bus.tx_valid), 32'(m_txv));
    check_val("tx_data",    32'(bus.tx_data),  32'(m_txd));
    check_val("fifo_level", 32'(fifo_level),   32'(mq.size()));
    check_val("overflow",   32'(overflow),     32'(m_ovf));
    check_val("drop_cnt",   32'(drop_cnt),     32'(m_drop));
    check_val("tx_err",     32'(tx_err),       32'(m_err));
    check_val("idle",       32'(idle),
              32'((mq.size() == 0) && (m_phase == P_FREE) && !bus.tx_busy));
  endtask

  // Apply this cycle's busy, clock once, then compare away from the edge.
  task automatic tick();
    drive_busy();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
    if (bus.tx_valid === 1'b1) obs.push_back(bus.tx_data);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (!((mq.size() == 0) && (m_phase == P_FREE)) && (n < 400)) begin
      tick();
      n++;
    end
    check_val(tag, 32'(n < 400), 32'd1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] burst_exp [6];
    logic [7:0] got_b;
    burst_exp[0] = 8'h01; burst_exp[1] = 8'h02; burst_exp[2] = 8'h03;
    burst_exp[3] = 8'h04; burst_exp[4] = 8'h05; burst_exp[5] = 8'h07;

    rst = 1'b0; enable = 1'b1; clr_stat = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_data = '0; bus.tx_busy = 1'b0;

    // Reset state
    tick();
    tick();
    check_val("rst_level", 32'(fifo_level), 32'd0);
    check_val("rst_txv",   32'(bus.tx_valid), 32'd0);
    check_val("rst_idle",  32'(idle), 32'd1);
    rst = 1'b1;

    // Single echo: byte at cycle 10, busy high for cycles 13..29
    for (int c = 10; c <= 31; c++) begin
      bus.rx_valid = (c == 10);
      bus.rx_data  = 8'hA5;
      man_busy     = (c >= 13) && (c <= 29);
      tick();
      if (c == 10) check_val("echo_level", 32'(fifo_level), 32'd1);
      if (c == 11) begin
        check_val("echo_txv", 32'(bus.tx_valid), 32'd1);
        check_val("echo_txd", 32'(bus.tx_data), 32'hA5);
      end
      if (c == 30) check_val("echo_idle", 32'(idle), 32'd1);
    end
    check_val("echo_err", 32'(tx_err), 32'd0);

    // Burst into a busy transmitter, then full FIFO with a same-cycle pop
    obs.delete();
    man_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'(i + 1);
      tick();
    end
    bus.rx_valid = 1'b0;
    check_val("burst_level", 32'(fifo_level), 32'd4);
    check_val("burst_ovf",   32'(overflow),   32'd1);
    check_val("burst_drop",  32'(drop_cnt),   32'd1);
    man_busy = 1'b0;
    tick();
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h07;
    tick();
    bus.rx_valid = 1'b0;
    check_val("fullpop_level", 32'(fifo_level), 32'd4);
    check_val("fullpop_drop",  32'(drop_cnt),   32'd1);
    check_val("fullpop_txd",   32'(bus.tx_data), 32'h02);
    manual   = 1'b0;
    em_fixed = 1'b1;
    drain("burst_drain");
    check_val("burst_count", 32'(obs.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      got_b = (i < obs.size()) ? obs[i] : 8'hxx;
      check_val("burst_order", 32'(got_b), 32'(burst_exp[i]));
    end

    // Busy timeout: busy never rises
    tick();
    obs.delete();
    manual = 1'b1; man_busy = 1'b0;
    bus.rx_valid = 1'b1; bus.rx_data = 8'h3C;
    tick();
    bus.rx_valid = 1'b0;
    for (int k = 2; k <= 45; k++) begin
      tick();
      if (k == 17) check_val("to_err_early", 32'(tx_err), 32'd0);
      if (k == 18) check_val("to_err",       32'(tx_err), 32'd1);
    end
    check_val("to_pulses", 32'(obs.size()), 32'd1);
    got_b = (obs.size() > 0) ? obs[0] : 8'hxx;
    check_val("to_byte", 32'(got_b), 32'h3C);

    // Drop saturation, then a clear that coincides with another drop
    man_busy = 1'b1;
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 310; i++) begin
      bus.rx_data = 8'($urandom);
      tick();
    end
    check_val("sat_drop", 32'(drop_cnt), 32'd255);
    check_val("sat_ovf",  32'(overflow), 32'd1);
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    bus.rx_valid = 1'b0;
    check_val("clr_drop", 32'(drop_cnt), 32'd0);
    check_val("clr_ovf",  32'(overflow), 32'd0);
    check_val("clr_err",  32'(tx_err),   32'd0);

    // Disabled receive, then reset while waiting for busy to fall
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.rx_valid = 1'b1; bus.rx_data = 8'(8'h90 + i);
      tick();
      bus.rx_valid = 1'b0;
      tick();
    end
    check_val("dis_level", 32'(fifo_level), 32'd4);
    check_val("dis_drop",  32'(drop_cnt),   32'd0);
    enable   = 1'b1;
    rst      = 1'b0;
    man_busy = 1'b0;
    tick();
    rst = 1'b1;
    check_val("mrst_level", 32'(fifo_level),  32'd0);
    check_val("mrst_txv",   32'(bus.tx_valid), 32'd0);
    check_val("mrst_txd",   32'(bus.tx_data), 32'd0);
    check_val("mrst_idle",  32'(idle),        32'd1);
    obs.delete();
    for (int i = 0; i < 20; i++) tick();
    check_val("mrst_no_tx", 32'(obs.size()), 32'd0);

    // Randomized traffic against a randomized transmitter
    manual   = 1'b0;
    em_fixed = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bus.rx_valid = ($urandom_range(0, 99) < 45);
      bus.rx_data  = 8'($urandom);
      enable       = ($urandom_range(0, 99) < 90);
      clr_stat     = ($urandom_range(0, 99) < 2);
      rst          = !($urandom_range(0, 999) < 3);
      tick();
    end
    bus.rx_valid = 1'b0;
    clr_stat     = 1'b0;
    rst          = 1'b1;
    enable       = 1'b1;
    drain("rand_drain");
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
